// File: rtl/debayer_frame_scheduler.sv
// debayer_frame_scheduler
// Shares one debayer datapath between the left and right raw frame buffers.
// Whole frames are granted round-robin. The debayer is held in reset between
// frames. While a frame is granted, the block generates the raster read
// address (with horizontal blanking) and a latency-aligned RGB write strobe,
// address and camera tag.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   enable              allow new grants (sampled in IDLE only)
//   req_l, req_r        level requests: a raw buffer holds a complete frame
//   done_l, done_r      one-cycle pulse when that side's frame is finished
//   busy                high from CLEAR through DONE inclusive
//   rd_sel              raw source select (0 left, 1 right)
//   rd_addr, deb_addr   raster read address y*SIZE_X+x
//   deb_reset           debayer reset
//   wr_en, wr_addr      RGB store write strobe/address (PIPE_LAT behind rd_addr)
//   wr_cam              camera tag for wr_addr
module debayer_frame_scheduler #(
    parameter int unsigned SIZE_X   = 640,
    parameter int unsigned SIZE_Y   = 480,
    parameter int unsigned SIZE_X_T = 160,
    parameter int unsigned PIPE_LAT = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        req_l,
    input  logic        req_r,
    output logic        done_l,
    output logic        done_r,
    output logic        busy,
    output logic        rd_sel,
    output logic [18:0] rd_addr,
    output logic        deb_reset,
    output logic [18:0] deb_addr,
    output logic        wr_en,
    output logic [18:0] wr_addr,
    output logic        wr_cam
);

    localparam int unsigned AW   = 19;
    localparam int unsigned LINE = SIZE_X + SIZE_X_T;
    localparam int unsigned XW   = (LINE > 1) ? $clog2(LINE) : 1;
    localparam int unsigned YW   = (SIZE_Y > 1) ? $clog2(SIZE_Y) : 1;
    localparam int unsigned DW   = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic [AW-1:0]   rd_addr_q, rd_addr_d;
    logic            rd_sel_q, rd_sel_d;
    logic            last_grant_q, last_grant_d;
    logic            done_l_q, done_l_d;
    logic            done_r_q, done_r_d;
    logic            busy_q, busy_d;
    logic            deb_reset_q, deb_reset_d;
    logic            en_q   [PIPE_LAT];
    logic            en_d   [PIPE_LAT];
    logic [AW-1:0]   wa_q   [PIPE_LAT];
    logic [AW-1:0]   wa_d   [PIPE_LAT];
    logic            cam_q  [PIPE_LAT];
    logic            cam_d  [PIPE_LAT];
    logic            active_c;
    logic            win_c;

    // State and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            drain_q      <= '0;
            rd_addr_q    <= '0;
            rd_sel_q     <= 1'b0;
            last_grant_q <= 1'b1;
            done_l_q     <= 1'b0;
            done_r_q     <= 1'b0;
            busy_q       <= 1'b0;
            deb_reset_q  <= 1'b1;
            for (int unsigned i = 0; i < PIPE_LAT; i++) begin
                en_q[i]  <= 1'b0;
                wa_q[i]  <= '0;
                cam_q[i] <= 1'b0;
            end
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            drain_q      <= drain_d;
            rd_addr_q    <= rd_addr_d;
            rd_sel_q     <= rd_sel_d;
            last_grant_q <= last_grant_d;
            done_l_q     <= done_l_d;
            done_r_q     <= done_r_d;
            busy_q       <= busy_d;
            deb_reset_q  <= deb_reset_d;
            for (int unsigned i = 0; i < PIPE_LAT; i++) begin
                en_q[i]  <= en_d[i];
                wa_q[i]  <= wa_d[i];
                cam_q[i] <= cam_d[i];
            end
        end
    end

    // Next-state, counters, arbitration and registered-output decode
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        drain_d      = drain_q;
        rd_addr_d    = rd_addr_q;
        rd_sel_d     = rd_sel_q;
        last_grant_d = last_grant_q;

        active_c = (state_q == S_RUN) && (32'(x_q) < SIZE_X);
        // Round-robin: on a tie grant the side not served last
        win_c = (req_l && req_r) ? ~last_grant_q : req_r;

        case (state_q)
            S_IDLE: begin
                if (enable && (req_l || req_r)) begin
                    state_d   = S_CLEAR;
                    rd_sel_d  = win_c;
                    x_d       = '0;
                    y_d       = '0;
                    rd_addr_d = '0;
                end
            end
            S_CLEAR: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                // Address advances only past active pixels, holds in blanking
                rd_addr_d = rd_addr_q + AW'(active_c);
                if (x_q == XW'(LINE - 1)) begin
                    x_d = '0;
                    if (y_q == YW'(SIZE_Y - 1)) begin
                        state_d = S_DRAIN;
                        drain_d = '0;
                    end else begin
                        y_d = y_q + YW'(1);
                    end
                end else begin
                    x_d = x_q + XW'(1);
                end
            end
            S_DRAIN: begin
                if (drain_q == DW'(PIPE_LAT - 1)) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            S_DONE: begin
                last_grant_d = rd_sel_q;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        done_l_d    = (state_d == S_DONE) && !rd_sel_q;
        done_r_d    = (state_d == S_DONE) && rd_sel_q;
        busy_d      = (state_d != S_IDLE);
        deb_reset_d = (state_d == S_IDLE) || (state_d == S_CLEAR) || (state_d == S_DONE);

        // Write-side delay line of (active, rd_addr, rd_sel)
        en_d[0]  = active_c;
        wa_d[0]  = rd_addr_q;
        cam_d[0] = rd_sel_q;
        for (int unsigned i = 1; i < PIPE_LAT; i++) begin
            en_d[i]  = en_q[i-1];
            wa_d[i]  = wa_q[i-1];
            cam_d[i] = cam_q[i-1];
        end
        if ((state_d == S_IDLE) || (state_d == S_CLEAR)) begin
            en_d[PIPE_LAT-1] = 1'b0;
        end
    end

    assign done_l    = done_l_q;
    assign done_r    = done_r_q;
    assign busy      = busy_q;
    assign rd_sel    = rd_sel_q;
    assign rd_addr   = rd_addr_q;
    assign deb_addr  = rd_addr_q;
    assign deb_reset = deb_reset_q;
    assign wr_en     = en_q[PIPE_LAT-1];
    assign wr_addr   = wa_q[PIPE_LAT-1];
    assign wr_cam    = cam_q[PIPE_LAT-1];

endmodule

// File: doc/debayer_frame_scheduler.md
# debayer_frame_scheduler

Frame-granular scheduler that shares one debayer datapath between the left and right camera raw frame buffers. It grants whole frames round-robin and holds the debayer in reset between frames. During each frame it generates the raster read/address sequence, including horizontal blanking, and produces a latency-aligned write strobe and address for the RGB frame store. It sits between the two raw capture buffers and the debayer, and drives the RGB buffer write port.

## Interface
Parameters:
- SIZE_X, 640, active pixels per line
- SIZE_Y, 480, lines per frame
- SIZE_X_T, 160, blanking cycles appended to every line
- PIPE_LAT, 2, cycles from deb_addr/raw presented to RGB valid at debayer output (≥1)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  high: new frames may be granted; low: the current frame completes, no new grant
- req_l  in  1  level; left raw buffer holds a complete frame
- req_r  in  1  level; right raw buffer holds a complete frame
- done_l  out  1  one-cycle pulse; left frame fully processed
- done_r  out  1  one-cycle pulse; right frame fully processed
- busy  out  1  high from grant until the DONE cycle inclusive
- rd_sel  out  1  raw source mux select (0 left, 1 right)
- rd_addr  out  19  raw buffer read address, y*SIZE_X+x
- deb_reset  out  1  drives the debayer reset
- deb_addr  out  19  drives the debayer address_in; equals rd_addr
- wr_en  out  1  RGB output valid, active pixels only
- wr_addr  out  19  RGB store address (rd_addr delayed PIPE_LAT)
- wr_cam  out  1  camera tag for wr_addr (rd_sel delayed PIPE_LAT)

## Operation
- States: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE:
  - deb_reset=1, busy=0.
  - If enable and any req, pick a winner and go to CLEAR.
- Arbitration is round-robin on last_grant:
  - If both requests are high, grant the side not granted last.
  - If only one is high, grant it.
  - After reset, last_grant=right, so left wins the first tie.
- CLEAR (1 cycle):
  - rd_sel=winner, deb_reset=1, busy=1.
  - x=0, y=0, rd_addr=0.
- RUN:
  - deb_reset=0.
  - x counts 0..SIZE_X+SIZE_X_T-1, then wraps to 0 and y increments.
  - A pixel is active when x<SIZE_X. rd_addr increments by 1 after each active cycle and holds through blanking.
  - On the last blanking cycle of line SIZE_Y-1, go to DRAIN.
  - RUN lasts N=SIZE_Y*(SIZE_X+SIZE_X_T) cycles.
- DRAIN: PIPE_LAT cycles; deb_reset=0; the delay pipe flushes.
- DONE (1 cycle):
  - Pulse done_l or done_r per rd_sel.
  - Update last_grant, then go to IDLE.
- Write path:
  - wr_en, wr_addr and wr_cam are a PIPE_LAT-deep shift of (active, rd_addr, rd_sel).
  - wr_en is forced 0 in IDLE and CLEAR.
- Requests:
  - Requests are sampled only in IDLE.
  - A req still high in the IDLE cycle after DONE is a new frame.
  - A req that drops mid-frame does not abort the frame.
- enable is sampled only in IDLE.
- Counter widths: x ≥ clog2(SIZE_X+SIZE_X_T), y ≥ clog2(SIZE_Y). rd_addr is 19 bits, and SIZE_X*SIZE_Y ≤ 2^19 is required.

## Timing
- Reset values:
  - State IDLE, last_grant=1.
  - deb_reset=1.
  - done_l=done_r=busy=rd_sel=wr_en=wr_cam=0.
  - rd_addr=deb_addr=wr_addr=0.
  - Delay pipe cleared.
- Reset asserted mid-frame: next cycle all outputs are at reset values and no done pulse is issued. The frame is abandoned and the requester keeps req high to retry.
- Request in IDLE at cycle t:
  - CLEAR at t+1.
  - RUN at t+2..t+1+N.
  - DRAIN for PIPE_LAT cycles.
  - DONE at t+2+N+PIPE_LAT.
  - IDLE at t+3+N+PIPE_LAT.
- First wr_en=1 at t+2+PIPE_LAT with wr_addr=0. Last wr_en is at t+1+N+PIPE_LAT-SIZE_X_T with wr_addr=SIZE_X*SIZE_Y-1.
- Exactly SIZE_X*SIZE_Y wr_en pulses per frame.
- deb_addr and rd_addr are registered outputs; a raw buffer read latency is absorbed in PIPE_LAT.

## Test plan
- SIZE_X=4, SIZE_Y=2, SIZE_X_T=2, PIPE_LAT=2; req_l=1 at t=0:
  - CLEAR t=1, done_l pulse at t=16.
  - wr_en high at t=4–7 (addr 0–3) and t=10–13 (addr 4–7), wr_cam=0.
- req_l=req_r=1 continuously:
  - grants alternate L,R,L,R; first grant is left.
  - done pulses are 17 cycles apart (IDLE→DONE cycle count +1).
- enable=0 with req_r=1: no CLEAR, busy=0, deb_reset=1 indefinitely. Raising enable gives CLEAR next cycle, rd_sel=1.
- reset asserted at mid-RUN (y=1, x=3): next cycle state IDLE, wr_en=0, rd_addr=0, deb_reset=1, no done pulse. Frame restarts from rd_addr 0.
- req_l dropped during RUN: frame still completes with 8 wr_en pulses and done_l.
- Default parameters, single left frame:
  - 307200 wr_en pulses, final wr_addr=307199.
  - done_l at t=384004.
